// File: rtl/wb_master.sv
// wb_master: single-outstanding command-to-bus bridge.
// A user command is latched, presented on a simple strobe/ack bus, and
// completed with a one-cycle rsp_valid pulse carrying read data and an
// error flag.
// Optional feature: define WB_MASTER_TIMEOUT_EN to abort a transfer that
// has waited TIMEOUT_CYCLES bus cycles without an acknowledge.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | cmd_ready high; waiting for cmd_valid
// BUS   | wb_strb high with the latched command; waiting for wb_ack
// RESP  | one-cycle rsp_valid pulse; always returns to IDLE
module wb_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       wb_strb,
  output logic       wb_we,
  output logic [7:0] wb_addr,
  output logic [7:0] wb_wdata,
  input  logic [7:0] wb_rdata,
  input  logic       wb_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       accept;
  logic       bus_done;
  logic       bus_abort;
  logic       we_q;
  logic [7:0] rdata_q;

  // Handshake decodes; everything visible is derived from the state register
  // so reset removes the strobe without waiting for a clock edge.
  assign cmd_ready = (state == IDLE);
  assign wb_strb   = (state == BUS);
  assign rsp_valid = (state == RESP);
  assign wb_we     = we_q & (state == BUS);
  assign rsp_rdata = rdata_q;
  assign accept    = (state == IDLE) & cmd_valid;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt;
  logic       err_q;

  // Counts bus cycles spent without an acknowledge; restarts on every accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 8'h00;
    end else if (accept) begin
      tmo_cnt <= 8'h00;
    end else if ((state == BUS) && !wb_ack) begin
      tmo_cnt <= tmo_cnt + 8'h01;
    end
  end

  // An acknowledge on the final allowed cycle still wins over the abort.
  assign bus_abort = (state == BUS) & ~wb_ack & (tmo_cnt == TMO_LAST);

  // Error flag is captured on every completion and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bus_done || bus_abort) begin
      err_q <= bus_abort;
    end
  end

  assign rsp_err = err_q;
`else
  assign bus_abort = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  assign bus_done = (state == BUS) & wb_ack;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; acks outside BUS have no effect.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = BUS;
        end
      end
      BUS: begin
        if (bus_done || bus_abort) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Command latch: bus address/data hold from accept until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      wb_addr  <= 8'h00;
      wb_wdata <= 8'h00;
    end else if (accept) begin
      we_q     <= cmd_we;
      wb_addr  <= cmd_addr;
      wb_wdata <= cmd_wdata;
    end
  end

  // Response data: read data on a normal read, zero for writes and aborts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 8'h00;
    end else if (bus_done) begin
      rdata_q <= we_q ? 8'h00 : wb_rdata;
    end else if (bus_abort) begin
      rdata_q <= 8'h00;
    end
  end

endmodule

// File: doc/wb_master.md
WB_MASTER -- requirements
Module: wb_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, cycles wb_strb may stay high without wb_ack before abort (valid range 2..255).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: cmd_valid  input  1  user request present.
REQ-005 Port: cmd_ready  output  1  block can accept a request.
REQ-006 Port: cmd_we  input  1  1 = write, 0 = read.
REQ-007 Port: cmd_addr  input  8  target address.
REQ-008 Port: cmd_wdata  input  8  write data; ignored for reads.
REQ-009 Port: rsp_valid  output  1  one-cycle completion pulse.
REQ-010 Port: rsp_rdata  output  8  read data; 8'h00 for writes and aborted transfers.
REQ-011 Port: rsp_err  output  1  completion was a timeout abort; qualified by rsp_valid.
REQ-012 Port: wb_strb  output  1  bus strobe to memory responder.
REQ-013 Port: wb_we  output  1  bus write enable.
REQ-014 Port: wb_addr  output  8  bus address.
REQ-015 Port: wb_wdata  output  8  bus write data.
REQ-016 Port: wb_rdata  input  8  bus read data from responder.
REQ-017 Port: wb_ack  input  1  responder acknowledge.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, BUS, RESP.
REQ-019 cmd_ready SHALL be 1 only in IDLE, decoded from state.
REQ-020 On a rising edge with cmd_valid=1 in IDLE, cmd_we/cmd_addr/cmd_wdata SHALL be latched, and the FSM SHALL enter BUS.
REQ-021 In BUS, wb_strb SHALL be 1, and wb_we/wb_addr/wb_wdata SHALL hold the latched values, stable for the whole transfer.
REQ-022 Outside BUS, wb_strb SHALL be 0, wb_we SHALL be 0, and wb_addr/wb_wdata SHALL hold their last values.
REQ-023 On a rising edge in BUS with wb_ack=1, the FSM SHALL enter RESP.
  - Read: wb_rdata SHALL be registered into rsp_rdata.
  - Write: rsp_rdata SHALL be set to 8'h00.
  - rsp_err SHALL be set to 0.
REQ-024 wb_ack SHALL be ignored in IDLE and RESP.
REQ-025 In RESP, rsp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL enter IDLE unconditionally.
REQ-026 rsp_rdata and rsp_err SHALL hold their values until the next completion.
REQ-027 Minimum cadence SHALL be one transfer per 3 cycles: accept edge, at least one BUS cycle, one RESP cycle.
REQ-028 A cmd_valid held high through RESP SHALL be accepted on the first edge after returning to IDLE, not earlier.

Reset
REQ-029 Asserting rst SHALL force, immediately and independent of clk: state IDLE, wb_strb 0, wb_we 0, wb_addr 8'h00, wb_wdata 8'h00, rsp_valid 0, rsp_rdata 8'h00, rsp_err 0, timeout counter 0.
REQ-030 A transfer in progress when rst asserts SHALL be dropped with no rsp_valid pulse.
REQ-031 After rst deasserts, cmd_ready SHALL be 1 and the first request SHALL be accepted on the next qualifying edge.

Configuration
REQ-032 Macro WB_MASTER_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entering BUS and increment each BUS cycle without wb_ack.
  - When the counter reaches TIMEOUT_CYCLES-1 with wb_ack=0, the FSM SHALL enter RESP with rsp_err=1 and rsp_rdata=8'h00.
  - wb_ack=1 on that same edge SHALL win: normal completion, rsp_err=0.
REQ-033 Macro WB_MASTER_TIMEOUT_EN undefined: no counter SHALL exist, BUS SHALL wait indefinitely for wb_ack, and rsp_err SHALL be constant 0.

Verification
REQ-034 Write 8'h5A to addr 8'h10; ack on the 3rd BUS cycle -> wb_strb high exactly 3 cycles with wb_we=1, wb_addr=8'h10, wb_wdata=8'h5A; one rsp_valid pulse, rsp_rdata=8'h00, rsp_err=0.
REQ-035 Read addr 8'h10; responder drives wb_rdata=8'h5A with ack -> rsp_valid pulse with rsp_rdata=8'h5A, rsp_err=0.
REQ-036 cmd_valid held high for 4 back-to-back reads with 1-cycle ack -> 4 rsp_valid pulses spaced exactly 3 cycles apart; cmd_ready low in BUS and RESP.
REQ-037 Stray wb_ack=1 pulses in IDLE and RESP -> no state change and no rsp_valid.
REQ-038 With WB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, read that is never acked -> wb_strb high 16 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=8'h00; next command accepted normally.
REQ-039 rst pulsed mid-BUS, between clock edges -> wb_strb drops the same cycle, no rsp_valid; a subsequent write to 8'h20 completes normally.
